// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit - program counter at the head of the fetch stage.
//
// Holds the current fetch address and advances it by INST_BYTES per cycle.
// Supports hazard stall and branch/jump redirect. After reset the PC is held
// for BOOT_HOLD clock edges (BOOT state) before fetch becomes valid (RUN).
// Redirects accepted during BOOT are parked in a pending register (last one
// wins) and applied on the first RUN edge, even under stall.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : a misaligned redirect is rejected and trap_o pulses for one cycle
//   undefined : redirects are accepted with the low address bits forced to 0,
//               trap_o is constant 0
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   stall_i         in   hazard stall, PC holds
//   redirect_i      in   load a new PC
//   redirect_addr_i in   redirect target [ADDR_W]
//   pc_o            out  current fetch address (registered) [ADDR_W]
//   pc_plus_o       out  pc_o + INST_BYTES, modulo 2^ADDR_W [ADDR_W]
//   valid_o         out  fetch at pc_o is valid (RUN)
//   boot_done_o     out  sticky, set on entering RUN
//   trap_o          out  one-cycle pulse on a rejected misaligned redirect
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned INST_BYTES = 4,
    parameter int unsigned BOOT_HOLD  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus_o,
    output logic              valid_o,
    output logic              boot_done_o,
    output logic              trap_o
);

    // Hold counter only ever reaches BOOT_HOLD-1.
    localparam int unsigned CNT_W = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BOOT_HOLD - 1);
    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t INIT_STATE     = (BOOT_HOLD == 0) ? ST_RUN : ST_BOOT;
    localparam logic   INIT_BOOT_DONE = (BOOT_HOLD == 0) ? 1'b1 : 1'b0;

    // True when an address has nonzero bits below instruction granularity.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return |(addr & LOW_MASK);
    endfunction

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [ADDR_W-1:0] pc_r, pc_nxt_s;
    logic              pend_r, pend_nxt_s;
    logic [ADDR_W-1:0] pend_addr_r, pend_addr_nxt_s;
    logic              boot_done_r, boot_done_nxt_s;
    logic              trap_r, trap_nxt_s;
    logic              redirect_ok_s;
    logic              reject_s;
    logic [ADDR_W-1:0] redirect_tgt_s;

`ifdef PC_ALIGN_CHECK_EN
    // A misaligned redirect is treated as if redirect_i were low.
    assign redirect_ok_s  = redirect_i && !is_misaligned(redirect_addr_i);
    assign reject_s       = redirect_i &&  is_misaligned(redirect_addr_i);
    assign redirect_tgt_s = redirect_addr_i;
`else
    // Every redirect is accepted; sub-instruction bits are dropped.
    assign redirect_ok_s  = redirect_i;
    assign reject_s       = 1'b0;
    assign redirect_tgt_s = redirect_addr_i & ~LOW_MASK;
`endif

    // Next-state and next-PC selection.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        pc_nxt_s        = pc_r;
        pend_nxt_s      = pend_r;
        pend_addr_nxt_s = pend_addr_r;
        boot_done_nxt_s = boot_done_r;
        trap_nxt_s      = reject_s;

        case (state_r)
            ST_BOOT: begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s     = ST_RUN;
                    boot_done_nxt_s = 1'b1;
                end else begin
                    state_nxt_s     = ST_BOOT;
                end
                // Park the target; a later redirect overwrites an earlier one.
                if (redirect_ok_s) begin
                    pend_nxt_s      = 1'b1;
                    pend_addr_nxt_s = redirect_tgt_s;
                end else begin
                    pend_nxt_s      = pend_r;
                end
            end
            ST_RUN: begin
                // Redirect and pending both beat stall (flush semantics).
                if (redirect_ok_s) begin
                    pc_nxt_s   = redirect_tgt_s;
                    pend_nxt_s = 1'b0;
                end else if (pend_r) begin
                    pc_nxt_s   = pend_addr_r;
                    pend_nxt_s = 1'b0;
                end else if (!stall_i) begin
                    pc_nxt_s   = pc_r + INC;
                end else begin
                    pc_nxt_s   = pc_r;
                end
            end
            default: begin
                state_nxt_s = INIT_STATE;
            end
        endcase
    end

    // State, PC and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= INIT_STATE;
            cnt_r       <= '0;
            pc_r        <= RESET_VEC;
            pend_r      <= 1'b0;
            pend_addr_r <= '0;
            boot_done_r <= INIT_BOOT_DONE;
            trap_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            pc_r        <= pc_nxt_s;
            pend_r      <= pend_nxt_s;
            pend_addr_r <= pend_addr_nxt_s;
            boot_done_r <= boot_done_nxt_s;
            trap_r      <= trap_nxt_s;
        end
    end

    assign pc_o        = pc_r;
    assign pc_plus_o   = pc_r + INC;
    assign valid_o     = (state_r == ST_RUN);
    assign boot_done_o = boot_done_r;
    assign trap_o      = trap_r;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit at the head of the fetch stage of the pipelined CPU. Holds the current fetch address and advances it by one instruction per cycle. Supports stall and branch/jump redirect, and holds for a configurable number of boot cycles after reset before fetch becomes valid. Feeds the instruction memory address and the IF/ID pipeline register.

## Interface
- `ADDR_W`, 32: width of all address signals.
- `RESET_VEC`, 0: PC value loaded on reset.
- `INST_BYTES`, 4: PC increment per instruction. Power of two, ≥1.
- `BOOT_HOLD`, 1: number of clock edges after reset release before the PC may advance. 0 means no hold.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `stall_i` input 1: hazard stall; the PC holds.
- `redirect_i` input 1: load a new PC (branch/jump/flush).
- `redirect_addr_i` input ADDR_W: redirect target.
- `pc_o` output ADDR_W: current fetch address (registered).
- `pc_plus_o` output ADDR_W: `pc_o + INST_BYTES`, combinational, modulo 2^ADDR_W.
- `valid_o` output 1: fetch at `pc_o` is valid (state RUN).
- `boot_done_o` output 1: sticky; set on entering RUN.
- `trap_o` output 1: one-cycle pulse on a rejected misaligned redirect. Driven only with `PC_ALIGN_CHECK_EN`; otherwise tied 0.

## Operation
- **States:**
  - BOOT: counting hold cycles.
  - RUN: normal fetch.
- **Reset (async assert):**
  - State, pc and outputs: state = BOOT, or RUN if BOOT_HOLD = 0; `pc_o` = RESET_VEC; `pc_plus_o` = RESET_VEC + INST_BYTES.
  - Flags: `valid_o` = 0, or 1 if BOOT_HOLD = 0; `boot_done_o` likewise; `trap_o` = 0.
  - Internal: hold counter = 0; pending-redirect flag = 0.
- **BOOT:**
  - On each edge the hold counter increments.
  - At the edge where counter == BOOT_HOLD−1, go to RUN and set `boot_done_o`.
  - `pc_o` never changes in BOOT.
- **Redirect during BOOT:**
  - An accepted `redirect_i` in BOOT stores the target in a pending register and sets the pending flag.
  - Several redirects during BOOT: the last one wins.
- **RUN, per edge, in priority order:**
  1. Accepted `redirect_i`: `pc_o` ← target; clear pending.
  2. Pending set: `pc_o` ← pending target; clear pending. This applies even when `stall_i` = 1.
  3. `stall_i` = 0: `pc_o` ← `pc_o` + INST_BYTES.
  4. Otherwise `pc_o` holds.
- **Redirect vs. stall:** redirect beats stall (flush semantics).
- **Wrap-around:** increment from 2^ADDR_W − INST_BYTES yields 0; no flag is raised.
- **Reset mid-operation:** an immediate return to the reset values above. Pending and hold state are discarded.

## Timing
- Latency:
  - Redirect at edge N: `pc_o` = target after edge N. `pc_plus_o` follows in the same cycle.
  - Stall is sampled at the edge; one cycle of `stall_i` = 1 gives one extra cycle of the same `pc_o`.
- BOOT_HOLD = 1, reset released before edge 1:
  - `pc_o` = RESET_VEC through edge 1; `valid_o` = 1 after edge 1.
  - `pc_o` = RESET_VEC + INST_BYTES after edge 2.
- BOOT_HOLD = k: first advance happens at edge k+1.
- `trap_o` is high for exactly the cycle after the rejecting edge.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - A redirect whose low log2(INST_BYTES) bits are nonzero is rejected.
  - The pending flag and `pc_o` are unaffected; the cycle behaves as if `redirect_i` = 0.
  - `trap_o` pulses.
- Undefined:
  - Every redirect is accepted with the low log2(INST_BYTES) bits forced to 0.
  - `trap_o` is constant 0.
- With INST_BYTES = 1 both behave identically: nothing is misaligned.

## Test plan
- **Boot hold:** defaults; release reset, `stall_i` = 0 → `pc_o` = 0x0 for edges 0–1, 0x4 after edge 2, 0x8 after edge 3; `valid_o` rises after edge 1.
- **Stall vs. redirect:** in RUN at pc 0x10, `stall_i` = 1 for 3 edges → `pc_o` stays 0x10. Then `stall_i` = 1 with `redirect_i` = 1, addr 0x200 → `pc_o` = 0x200 next cycle.
- **Boot redirect:** BOOT_HOLD = 3; redirect 0x40, then 0x80, during BOOT → first RUN edge gives 0x80, followed by 0x84.
- **Wrap-around:** ADDR_W = 8, `pc_o` = 0xFC → advances to 0x00; `pc_plus_o` at 0xFC reads 0x00.
- **Misaligned redirect:** redirect to 0x102.
  - With `PC_ALIGN_CHECK_EN`: `pc_o` continues its increment and `trap_o` = 1 for one cycle.
  - Without it: `pc_o` = 0x100.
- **Reset mid-run:** assert `rst_n` = 0 between edges while pc = 0x300 and pending is set → `pc_o` = RESET_VEC immediately, `valid_o` = 0, and the pending target is never applied.
